// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer. Each iteration borrows the
// shared ADD/SUB ALU for one step; the result lands in hi/lo when done pulses.
// Optional feature: define MDU_EARLY_OUT_EN to end multiplies early once the remaining
// multiplier bits are all zero (divides keep the fixed latency).
module mdu_sequencer #(
   parameter int         DATA_W  = 32,
   parameter logic [3:0] ALU_ADD = 4'b0001,
   parameter logic [3:0] ALU_SUB = 4'b0010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              abort,
   input  logic [DATA_W-1:0] alu_res,
   output logic [DATA_W-1:0] alu_data1,
   output logic [DATA_W-1:0] alu_data2,
   output logic [5:0]        alu_shamt,
   output logic [3:0]        alu_ctrl,
   output logic              alu_own,
   output logic              busy,
   output logic              done,
   output logic              div_zero,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);
   localparam int CW = $clog2(DATA_W);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;
   state_t state, state_nxt;

   // a_q/b_q keep the raw operands (signs, divide-by-zero result); opnd holds the
   // magnitude of the multiplicand or divisor. acc_hi/acc_lo are product or rem/dividend.
   logic [DATA_W-1:0] a_q, b_q, opnd, acc_hi, acc_lo;
   logic [1:0]        op_q;
   logic              neg_res, neg_rem;
   logic [CW-1:0]     cnt;

   logic                is_div, is_sgn, sa, sb;
   logic [DATA_W-1:0]   part;
   logic                take, carry, early_exit;
   logic [2*DATA_W:0]   prod_w;
   logic [2*DATA_W-1:0] prod_next, prod_fix;
   logic [DATA_W-1:0]   q_fix, r_fix;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
      return s ? -v : v;
   endfunction

   assign is_div    = op_q[1];
   assign is_sgn    = ~op_q[0];
   assign sa        = is_sgn & a_q[DATA_W-1];
   assign sb        = is_sgn & b_q[DATA_W-1];
   assign alu_shamt = '0;

   // Iteration step arithmetic and final sign fix-up, shared by the datapath register.
   always_comb begin
      part       = {acc_hi[DATA_W-2:0], acc_lo[DATA_W-1]};
      take       = acc_hi[DATA_W-1] | (part >= opnd);
      carry      = alu_res < acc_hi;
      prod_w     = {carry, alu_res, acc_lo};
      prod_next  = prod_w[2*DATA_W:1];
      early_exit = 1'b0;
`ifdef MDU_EARLY_OUT_EN
      begin
         logic [2*DATA_W:0] prod_sh;
         logic [CW:0]       sh;
         sh      = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
         prod_sh = prod_w >> sh;
         // multiplier bits still to consume after this step live in acc_lo[cnt:1]
         if (!is_div && ((acc_lo >> 1) & ((DATA_W'(1) << cnt) - DATA_W'(1))) == '0) begin
            early_exit = 1'b1;
            prod_next  = prod_sh[2*DATA_W-1:0];
         end
      end
`endif
      prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      q_fix    = neg_res ? -acc_lo : acc_lo;
      r_fix    = neg_rem ? -acc_hi : acc_hi;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort beats everything, including a same-cycle start.
   always_comb begin
      state_nxt = state;
      if (state == S_IDLE) begin
         if (start && !abort) state_nxt = S_PREP;
      end else if (abort) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_PREP:  state_nxt = S_ITER;
            S_ITER:  if (cnt == '0 || early_exit) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs: ALU operands only while iterating, otherwise a quiet ADD of zeros.
   always_comb begin
      alu_own   = 1'b0;
      alu_data1 = '0;
      alu_data2 = '0;
      alu_ctrl  = ALU_ADD;
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      if (state == S_ITER) begin
         alu_own = 1'b1;
         if (is_div) begin
            alu_data1 = part;
            alu_data2 = opnd;
            alu_ctrl  = ALU_SUB;
         end else begin
            alu_data1 = acc_hi;
            alu_data2 = acc_lo[0] ? opnd : '0;
         end
      end
   end

   // Datapath: operand capture, magnitude prep, one step per ITER cycle, hi/lo commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0; b_q <= '0; opnd <= '0; acc_hi <= '0; acc_lo <= '0;
         op_q <= '0; neg_res <= 1'b0; neg_rem <= 1'b0; cnt <= '0;
         hi <= '0; lo <= '0; div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start && !abort) begin
               op_q     <= op;
               a_q      <= rs_val;
               b_q      <= rt_val;
               div_zero <= 1'b0;
            end
            S_PREP: if (!abort) begin
               acc_hi  <= '0;
               cnt     <= CW'(DATA_W-1);
               neg_res <= sa ^ sb;
               neg_rem <= sa;
               if (is_div) begin
                  acc_lo <= mag(a_q, sa);
                  opnd   <= mag(b_q, sb);
               end else begin
                  acc_lo <= mag(b_q, sb);
                  opnd   <= mag(a_q, sa);
               end
            end
            S_ITER: if (!abort) begin
               cnt <= cnt - 1'b1;
               if (is_div) begin
                  acc_hi <= take ? alu_res : part;
                  acc_lo <= {acc_lo[DATA_W-2:0], take};
               end else begin
                  {acc_hi, acc_lo} <= prod_next;
               end
            end
            S_FIX: if (!abort) begin
               if (is_div && b_q == '0) begin
                  hi       <= a_q;
                  lo       <= '1;
                  div_zero <= 1'b1;
               end else if (is_div) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed vector table, abort/reset sequences and randomized ops
// compared against an arithmetic reference model.
module tb_mdu_sequencer;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] rs_val = '0, rt_val = '0, alu_res;
   logic [31:0] alu_data1, alu_data2, hi, lo;
   logic [5:0]  alu_shamt;
   logic [3:0]  alu_ctrl;
   logic        alu_own, busy, done, div_zero;

   int n_chk = 0, n_pass = 0;

   mdu_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
      .abort(abort), .alu_res(alu_res), .alu_data1(alu_data1), .alu_data2(alu_data2),
      .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl), .alu_own(alu_own), .busy(busy),
      .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // shared ALU model: add or subtract
   assign alu_res = (alu_ctrl == 4'b0010) ? alu_data1 - alu_data2 : alu_data1 + alu_data2;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output logic dz);
      logic [63:0] p, ax, bx;
      int sa, sb;
      dz = 1'b0;
      case (o)
         2'b00: begin
            ax = {{32{a[31]}}, a}; bx = {{32{b[31]}}, b};
            p = ax * bx; {h, l} = p;
         end
         2'b01: begin
            ax = {32'h0, a}; bx = {32'h0, b};
            p = ax * bx; {h, l} = p;
         end
         default: begin
            if (b == 32'h0) begin
               h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (o == 2'b11) begin
               h = a % b; l = a / b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               h = 32'h0; l = 32'h8000_0000;
            end else begin
               sa = a; sb = b;
               h = sa % sb; l = sa / sb;
            end
         end
      endcase
   endfunction

   // edges from the start edge to the edge at which done rises
   function automatic int ref_lat(input logic [1:0] o, input logic [31:0] b);
      int idx;
      logic [31:0] m;
      idx = 0;
      m = (o == 2'b00 && b[31]) ? -b : b;
      for (int i = 0; i < 32; i++) if (m[i]) idx = i;
`ifdef MDU_EARLY_OUT_EN
      if (!o[1]) return 3 + idx;
`endif
      return 34 + idx - idx;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input string nm);
      int  e;
      bit  got;
      e = 0; got = 1'b0;
      @(negedge clk);
      op = o; rs_val = a; rt_val = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({nm, " busy"}, {63'h0, busy}, 64'h1);
      while (e < 200 && !got) begin
         @(posedge clk); #1;
         e++;
         if (e == 1) chk({nm, " alu_own"}, {63'h0, alu_own}, 64'h1);
         if (done) got = 1'b1;
      end
      chk({nm, " latency"}, 64'(e), 64'(ref_lat(o, b)));
      chk({nm, " hi"}, {32'h0, hi}, {32'h0, eh});
      chk({nm, " lo"}, {32'h0, lo}, {32'h0, el});
      chk({nm, " div_zero"}, {63'h0, div_zero}, {63'h0, edz});
      @(posedge clk); #1;
      chk({nm, " done pulse"}, {62'h0, done, busy}, 64'h0);
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [31:0] a, b, eh, el;
      logic        dz;
   } vec_t;

   vec_t vt[11];

   initial begin
      logic [31:0] eh, el, ra, rb;
      logic        edz;
      logic [1:0]  ro;
      bit          seen;

      vt[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
      vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
      vt[2]  = '{2'b11, 32'd100,       32'd7,        32'd2,         32'd14,         1'b0};
      vt[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      vt[4]  = '{2'b11, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1};
      vt[5]  = '{2'b01, 32'd1,         32'd1,        32'd0,         32'd1,          1'b0};
      vt[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
      vt[7]  = '{2'b10, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
      vt[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
      vt[9]  = '{2'b00, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        32'h8000_0000, 1'b0};
      vt[10] = '{2'b01, 32'd9,         32'd3,        32'd0,         32'd27,         1'b0};

      // reset state
      #1;
      chk("reset outs", {busy, done, alu_own, div_zero, alu_shamt}, 64'h0);
      chk("reset hilo", {hi, lo}, 64'h0);
      chk("reset alu data", {alu_data1, alu_data2}, 64'h0);
      chk("reset alu_ctrl", {60'h0, alu_ctrl}, 64'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++)
         run_op(vt[i].o, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].dz, $sformatf("vec%0d", i));

      // abort with start held high: no done, hi/lo kept, then a new start accepted
      @(negedge clk);
      op = 2'b11; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      if (done) seen = 1'b1;
      chk("abort idle", {63'h0, busy}, 64'h0);
      chk("abort no done", {63'h0, seen}, 64'h0);
      chk("abort hilo kept", {hi, lo}, {32'h0, 32'd27});
      @(negedge clk);
      abort = 1'b0; op = 2'b01; rs_val = 32'd6; rt_val = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart busy", {63'h0, busy}, 64'h1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midop reset outs", {busy, done, alu_own, div_zero, alu_shamt}, 64'h0);
      chk("midop reset hilo", {hi, lo}, 64'h0);
      chk("midop reset alu", {alu_data1, alu_data2}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, "post reset");

      // randomized ops against the reference model
      for (int i = 0; i < 50; i++) begin
         ro = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0: ra = 32'h0;
            1: ra = 32'h8000_0000;
            2: ra = 32'hFFFF_FFFF;
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: rb = 32'h0;
            1: rb = 32'hFFFF_FFFF;
            2: rb = 32'h1;
            3, 4: rb = $urandom_range(0, 300);
            default: rb = $urandom;
         endcase
         ref_model(ro, ra, rb, eh, el, edz);
         run_op(ro, ra, rb, eh, el, edz, $sformatf("rnd%0d op%0d %h %h", i, ro, ra, rb));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
